// File: rtl/approx_mult_if.sv
// Valid/ready operand and result stream for approx_mult_pipe.
// The producer/consumer side uses the master modport, the multiplier uses slave.
interface approx_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [1:0]           MODE;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   R;

  modport master (
    output in_valid, A, B, MODE, out_ready,
    input  in_ready, out_valid, R
  );

  modport slave (
    input  in_valid, A, B, MODE, out_ready,
    output in_ready, out_valid, R
  );
endinterface

// File: rtl/approx_mult_pipe.sv
// Pipelined approximate unsigned multiplier built from 4x4 tiles.
// Stages: S0 operand capture, S1 tile products, S2 accumulated sum, S3 output register.
// A beat accepted at edge n is presented on R/out_valid after edge n+3.
// Optional feature: define ERR_STAT_EN to track mismatches against the exact product.
module approx_mult_pipe #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned APPROX_LSB = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  approx_mult_if.slave       bus,
  input  logic               err_clr,
  output logic [31:0]        err_count,
  output logic [2*WIDTH-1:0] err_max
);
  localparam int unsigned K  = WIDTH / 4;
  localparam int unsigned NT = K * K;
  localparam int unsigned PW = 2 * WIDTH;
  // Result bits that use OR accumulation in approximate-accumulation mode.
  localparam logic [PW-1:0] LowMask = {PW{1'b1}} >> (PW - APPROX_LSB);

  logic en;

  logic             v0_q, v0_d;
  logic [WIDTH-1:0] a0_q, a0_d, b0_q, b0_d;
  logic [1:0]       mode0_q, mode0_d;

  logic             v1_q, v1_d;
  logic [7:0]       tile_q [NT];
  logic [7:0]       tile_d [NT];
  logic [7:0]       tile_c [NT];
  logic             accm1_q, accm1_d;

  logic             v2_q, v2_d;
  logic [PW-1:0]    sum2_q, sum2_d, sum_c;

  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    r_q, r_d;

  logic [PW-1:0]    aligned [NT];

  // Whole pipeline stalls only when the result is held for a busy consumer.
  assign en           = !out_valid_q | bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = out_valid_q;
  assign bus.R         = r_q;

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      localparam int unsigned T = gi * K + gj;
      logic [3:0] an, bn;
      logic [7:0] p;
      assign an = a0_q[4*gi +: 4];
      assign bn = b0_q[4*gj +: 4];
      // Tile product; approximate tiles rebuild bits [1:0] without carries.
      always_comb begin
        p = {4'b0, an} * {4'b0, bn};
        if (mode0_q[0] && (T != NT - 1)) begin
          p[1:0] = {(an[1] & bn[0]) | (an[0] & bn[1]), an[0] & bn[0]};
        end
      end
      assign tile_c[T]  = p;
      assign aligned[T] = {{(PW - 8){1'b0}}, tile_q[T]} << (4 * (gi + gj));
    end
  end

  // Exact sum, or carry-free OR for the low bits with an exact sum above them.
  always_comb begin
    logic [PW-1:0] exact_sum, hi_sum, lo_or;
    exact_sum = '0;
    hi_sum    = '0;
    lo_or     = '0;
    for (int unsigned t = 0; t < NT; t++) begin
      exact_sum = exact_sum + aligned[t];
      hi_sum    = hi_sum + (aligned[t] & ~LowMask);
      lo_or     = lo_or | (aligned[t] & LowMask);
    end
    sum_c = accm1_q ? (hi_sum | lo_or) : exact_sum;
  end

  // Stage advance: every stage loads from its predecessor when enabled, else holds.
  always_comb begin
    v0_d        = v0_q;
    a0_d        = a0_q;
    b0_d        = b0_q;
    mode0_d     = mode0_q;
    v1_d        = v1_q;
    tile_d      = tile_q;
    accm1_d     = accm1_q;
    v2_d        = v2_q;
    sum2_d      = sum2_q;
    out_valid_d = out_valid_q;
    r_d         = r_q;
    if (en) begin
      v0_d        = bus.in_valid;
      a0_d        = bus.A;
      b0_d        = bus.B;
      mode0_d     = bus.MODE;
      v1_d        = v0_q;
      tile_d      = tile_c;
      accm1_d     = mode0_q[1];
      v2_d        = v1_q;
      sum2_d      = sum_c;
      out_valid_d = v2_q;
      r_d         = sum2_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      a0_q        <= '0;
      b0_q        <= '0;
      mode0_q     <= '0;
      v1_q        <= 1'b0;
      tile_q      <= '{default: '0};
      accm1_q     <= 1'b0;
      v2_q        <= 1'b0;
      sum2_q      <= '0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
    end else begin
      v0_q        <= v0_d;
      a0_q        <= a0_d;
      b0_q        <= b0_d;
      mode0_q     <= mode0_d;
      v1_q        <= v1_d;
      tile_q      <= tile_d;
      accm1_q     <= accm1_d;
      v2_q        <= v2_d;
      sum2_q      <= sum2_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
    end
  end

`ifdef ERR_STAT_EN
  logic [PW-1:0] ex1_q, ex1_d, ex2_q, ex2_d, ex3_q, ex3_d;
  logic [PW-1:0] diff;
  logic [PW-1:0] err_max_q, err_max_d;
  logic [31:0]   err_count_q, err_count_d;

  // Exact product travels alongside the tile pipeline, aligned with R at S3.
  always_comb begin
    ex1_d = ex1_q;
    ex2_d = ex2_q;
    ex3_d = ex3_q;
    if (en) begin
      ex1_d = {{WIDTH{1'b0}}, a0_q} * {{WIDTH{1'b0}}, b0_q};
      ex2_d = ex1_q;
      ex3_d = ex2_q;
    end
  end

  // Error statistics update on each delivered result; clear wins.
  always_comb begin
    diff        = (ex3_q > r_q) ? (ex3_q - r_q) : (r_q - ex3_q);
    err_count_d = err_count_q;
    err_max_d   = err_max_q;
    if (err_clr) begin
      err_count_d = '0;
      err_max_d   = '0;
    end else if (out_valid_q && bus.out_ready && (r_q != ex3_q)) begin
      if (err_count_q != '1) err_count_d = err_count_q + 32'd1;
      if (diff > err_max_q) err_max_d = diff;
    end
  end

  // Exact-product pipeline and error statistic registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex1_q       <= '0;
      ex2_q       <= '0;
      ex3_q       <= '0;
      err_count_q <= '0;
      err_max_q   <= '0;
    end else begin
      ex1_q       <= ex1_d;
      ex2_q       <= ex2_d;
      ex3_q       <= ex3_d;
      err_count_q <= err_count_d;
      err_max_q   <= err_max_d;
    end
  end

  assign err_count = err_count_q;
  assign err_max   = err_max_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
  assign err_max        = '0;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe (WIDTH=8, APPROX_LSB=8).
// Directed cases from the block description followed by a randomized stream
// scored against a nibble-tile arithmetic model. Honors ERR_STAT_EN.
module tb_approx_mult_pipe;
  localparam int unsigned W  = 8;
  localparam int unsigned AL = 8;
  localparam int unsigned PW = 2 * W;

  logic          clk;
  logic          rst;
  logic          err_clr;
  logic [31:0]   err_count;
  logic [PW-1:0] err_max;

  approx_mult_if #(.WIDTH(W)) bus ();

  approx_mult_pipe #(.WIDTH(W), .APPROX_LSB(AL)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .err_clr  (err_clr),
    .err_count(err_count),
    .err_max  (err_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_cmp;
  int unsigned   n_err;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exa_q[$];
  logic [PW-1:0] got_q[$];
  logic          hold_pend;
  logic [PW-1:0] hold_r;
`ifdef ERR_STAT_EN
  logic [31:0]   m_cnt;
  logic [PW-1:0] m_max;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Product as defined by the tile rules, using plain integer arithmetic.
  function automatic logic [PW-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] md);
    longint unsigned av, bv, an, bn, t, al, ex, hi, lo, lmask, b1, b0;
    int unsigned k;
    av = a; bv = b; k = W / 4;
    ex = 0; hi = 0; lo = 0;
    lmask = (64'd1 << AL) - 64'd1;
    for (int unsigned i = 0; i < k; i++) begin
      for (int unsigned j = 0; j < k; j++) begin
        an = (av >> (4 * i)) & 64'hF;
        bn = (bv >> (4 * j)) & 64'hF;
        t  = an * bn;
        if (md[0] && !((i == k - 1) && (j == k - 1))) begin
          b1 = (((an >> 1) & bn) | (an & (bn >> 1))) & 64'd1;
          b0 = an & bn & 64'd1;
          t  = (t & ~64'h3) | (b1 << 1) | b0;
        end
        al = t << (4 * (i + j));
        ex = ex + al;
        hi = hi + (al & ~lmask);
        lo = lo | (al & lmask);
      end
    end
    return md[1] ? PW'(hi | lo) : PW'(ex);
  endfunction

  // One clock cycle: drive, observe/score, then advance past the edge.
  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] md, input logic ordy, input logic clr,
                      output logic acc);
    logic [PW-1:0] e, x;
    bus.in_valid  = iv;
    bus.A         = a;
    bus.B         = b;
    bus.MODE      = md;
    bus.out_ready = ordy;
    err_clr       = clr;
    #1;
`ifdef ERR_STAT_EN
    check("err_count", err_count, m_cnt);
    check("err_max", 32'(err_max), 32'(m_max));
`else
    check("err_count_off", err_count, 32'd0);
    check("err_max_off", 32'(err_max), 32'd0);
`endif
    check("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid | ordy));
    if (exp_q.size() == 0) check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    if (hold_pend) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_R", 32'(bus.R), 32'(hold_r));
    end
    acc = iv & bus.in_ready;
    if (bus.out_valid && ordy && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      x = exa_q.pop_front();
      check("R", 32'(bus.R), 32'(e));
      got_q.push_back(bus.R);
`ifdef ERR_STAT_EN
      if (!clr && e != x) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (((x > e) ? x - e : e - x) > m_max) m_max = (x > e) ? x - e : e - x;
      end
`endif
    end
`ifdef ERR_STAT_EN
    if (clr) begin
      m_cnt = '0;
      m_max = '0;
    end
`endif
    if (acc) begin
      exp_q.push_back(model_r(a, b, md));
      exa_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
    end
    hold_pend = bus.out_valid & !ordy;
    hold_r    = bus.R;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 2'd0, 1'b1, 1'b0, acc);
  endtask

  // Hold reset for n edges; returns just after the last edge with rst still high.
  task automatic do_reset(input int n);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    err_clr       = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    exp_q.delete();
    exa_q.delete();
    hold_pend = 1'b0;
`ifdef ERR_STAT_EN
    m_cnt = '0;
    m_max = '0;
`endif
  endtask

  initial begin
    logic acc;
    int   base, idx, hold;
    logic [W-1:0] sa [5];
    logic [W-1:0] sb [5];
    logic [1:0]   sm [5];
    n_cmp = 0; n_err = 0; hold_pend = 1'b0; hold_r = '0;
    bus.A = '0; bus.B = '0; bus.MODE = '0;

    // Reset state.
    do_reset(2);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_R", 32'(bus.R), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_err_count", err_count, 32'd0);
    check("rst_err_max", 32'(err_max), 32'd0);
    rst = 1'b0;

    // 1: exact 0xFF*0xFF, latency of three edges, single-cycle valid.
    step(1'b1, 8'hFF, 8'hFF, 2'd0, 1'b1, 1'b0, acc);
    check("t1_accept", 32'(acc), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("t1_lat_valid", 32'(bus.out_valid), 32'd0);
      step(1'b0, '0, '0, 2'd0, 1'b1, 1'b0, acc);
    end
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_R", 32'(bus.R), 32'h0000_FE01);
    step(1'b0, '0, '0, 2'd0, 1'b1, 1'b0, acc);
    check("t1_one_cycle", 32'(bus.out_valid), 32'd0);

    // 2: approximate tile 3*3 versus exact.
    base = got_q.size();
    step(1'b1, 8'h03, 8'h03, 2'd1, 1'b1, 1'b0, acc);
    step(1'b1, 8'h03, 8'h03, 2'd0, 1'b1, 1'b0, acc);
    drain(6);
    check("t2_count", got_q.size() - base, 32'd2);
    if (got_q.size() - base == 2) begin
      check("t2_R_approx", 32'(got_q[base]), 32'h000B);
      check("t2_R_exact", 32'(got_q[base+1]), 32'h0009);
    end

    // 3: approximate accumulation, with and without approximate tiles.
    base = got_q.size();
    step(1'b1, 8'hFF, 8'hFF, 2'd2, 1'b1, 1'b0, acc);
    step(1'b1, 8'hFF, 8'hFF, 2'd3, 1'b1, 1'b0, acc);
    drain(6);
    check("t3_count", got_q.size() - base, 32'd2);
    if (got_q.size() - base == 2) begin
      check("t3_R_mode2", 32'(got_q[base]), 32'hFDF1);
      check("t3_R_mode3", 32'(got_q[base+1]), 32'hFDF3);
    end

    // 4: five-beat stream with the consumer stalling after the first result.
    for (int k = 0; k < 5; k++) begin
      sa[k] = W'($urandom); sb[k] = W'($urandom); sm[k] = 2'($urandom);
    end
    base = got_q.size(); idx = 0; hold = 0;
    for (int c = 0; c < 40 && got_q.size() - base < 5; c++) begin
      logic ordy;
      ordy = 1'b1;
      if (got_q.size() - base == 1 && hold < 4) begin
        ordy = 1'b0;
        hold++;
      end
      if (idx < 5) step(1'b1, sa[idx], sb[idx], sm[idx], ordy, 1'b0, acc);
      else         step(1'b0, '0, '0, 2'd0, ordy, 1'b0, acc);
      if (acc) idx++;
    end
    check("t4_results", got_q.size() - base, 32'd5);
    check("t4_sent", 32'(idx), 32'd5);
    check("t4_no_leftover", exp_q.size(), 32'd0);

    // 5: reset with beats in flight discards them.
    for (int k = 0; k < 4; k++) step(1'b1, W'($urandom), W'($urandom), 2'($urandom), 1'b0,
                                     1'b0, acc);
    check("t5_pre_valid", 32'(bus.out_valid), 32'd1);
    base = got_q.size();
    do_reset(1);
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_R", 32'(bus.R), 32'd0);
    rst = 1'b0;
    drain(8);
    check("t5_no_stale", got_q.size() - base, 32'd0);

    // 6: error statistics (zero when the feature is absent), then clear.
    step(1'b1, 8'hFF, 8'hFF, 2'd2, 1'b1, 1'b0, acc);
    step(1'b1, 8'hFF, 8'hFF, 2'd3, 1'b1, 1'b0, acc);
    step(1'b1, 8'hFF, 8'hFF, 2'd0, 1'b1, 1'b0, acc);
    drain(6);
`ifdef ERR_STAT_EN
    check("t6_err_count", err_count, 32'd2);
    check("t6_err_max", 32'(err_max), 32'h10);
`else
    check("t6_err_count", err_count, 32'd0);
    check("t6_err_max", 32'(err_max), 32'd0);
`endif
    step(1'b0, '0, '0, 2'd0, 1'b1, 1'b1, acc);
    check("t6_clr_count", err_count, 32'd0);
    check("t6_clr_max", 32'(err_max), 32'd0);

    // Randomized traffic with random back-pressure and occasional clears.
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 4) != 0, W'($urandom), W'($urandom), 2'($urandom),
           ($urandom % 4) != 0, ($urandom % 50) == 0, acc);
    end
    drain(10);
    check("rand_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
